mfp_sprite_fetch: RTL

Scanline sprite engine at the read end of the sprite RAM's secondary port. On each line-start pulse it walks the sprite attribute table through `SPRITE_ADDR`/`SPRITE_DATA`, selects up to `MAX_SLOTS` sprites that intersect the requested line, and fetches each one's bitmap row into a back-bank line buffer. At the next line start the banks swap. The front bank then answers per-pixel queries from the VGA pipeline with pixel-on and colour.

---
 rtl/mfp_sprite_fetch.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mfp_sprite_fetch.sv
// Scanline sprite engine: walks the attribute table on each line start, keeps up to MAX_SLOTS row bitmaps in a double-buffered line buffer, and answers per-pixel queries from the front bank.
// Latency: a scan takes 2*NUM_SPRITES + 2*accepted cycles after line_start; the pixel query result is registered and appears one cycle after pix_x.
// Backpressure: none. The RAM read port has a fixed 1-cycle latency with no handshake, and a line_start during a scan aborts the scan and restarts it.
//
// Ports:
//   HCLK, HRESET             clock, synchronous active-high reset
//   line_start, line_y       swap banks and scan for line_y (sampled on the pulse)
//   SPRITE_ADDR, SPRITE_DATA sprite RAM read port (byte address out, word back one cycle later)
//   pix_x                    pixel column queried against the front bank
//   pixel_on, pixel_color    registered query result (lowest slot wins)
//   busy, overflow           scan in progress; last completed scan had more visible sprites than slots

module mfp_sprite_fetch #(
    parameter int          NUM_SPRITES = 32,
    parameter int          MAX_SLOTS   = 8,
    parameter logic [11:0] ATTR_BASE   = 12'h000,
    parameter logic [11:0] IMG_BASE    = 12'h400
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    output logic [11:0] SPRITE_ADDR,
    input  logic [31:0] SPRITE_DATA,
    input  logic [9:0]  pix_x,
    output logic        pixel_on,
    output logic [5:0]  pixel_color,
    output logic        busy,
    output logic        overflow
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int SW = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
    localparam int CW = $clog2(MAX_SLOTS + 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_SPRITES - 1);
    localparam logic [CW-1:0] SLOTS_FULL = CW'(MAX_SLOTS);

    typedef struct packed {
        logic        vld;
        logic [9:0]  x;
        logic [5:0]  col;
        logic [15:0] bits;
    } slot_t;

    typedef enum logic [2:0] {
        IDLE,
        ATTR_ADDR,
        ATTR_CHK,
        ROW_ADDR,
        ROW_CAP
    } state_t;

    state_t        state;
    slot_t         slots [2][MAX_SLOTS];
    logic          bank_sel;     // front bank index; the back bank is ~bank_sel
    logic [IW-1:0] idx;
    logic [CW-1:0] slot_cnt;
    logic [9:0]    scan_y;
    logic [9:0]    cur_x;
    logic [5:0]    cur_col;
    logic          cur_odd;      // dy[0]: which half of the image word holds the row
    logic          pend_ovf;

    // Attribute decode, valid while in ATTR_CHK (SPRITE_DATA holds the attribute word).
    logic [9:0]  attr_dy;
    logic        attr_vis;
    logic        slots_full;
    logic [11:0] attr_addr_next;
    logic [11:0] row_addr;

    assign attr_dy        = scan_y - SPRITE_DATA[25:16];
    assign attr_vis       = SPRITE_DATA[31] && (attr_dy < 10'd16);
    assign slots_full     = (slot_cnt == SLOTS_FULL);
    assign attr_addr_next = ATTR_BASE + 12'({idx + 1'b1, 2'b00});
    assign row_addr       = IMG_BASE + {2'b00, SPRITE_DATA[30:26], 5'b00000}
                                     + {7'b0000000, attr_dy[3:1], 2'b00};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            bank_sel    <= 1'b0;
            idx         <= '0;
            slot_cnt    <= '0;
            scan_y      <= '0;
            cur_x       <= '0;
            cur_col     <= '0;
            cur_odd     <= 1'b0;
            pend_ovf    <= 1'b0;
            SPRITE_ADDR <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < MAX_SLOTS; s++) begin
                    slots[b][s] <= '0;
                end
            end
        end else if (line_start) begin
            // Also the abort path: the partially built back bank becomes the front,
            // and overflow keeps the value of the last completed scan.
            bank_sel <= ~bank_sel;
            for (int s = 0; s < MAX_SLOTS; s++) begin
                slots[bank_sel][s].vld <= 1'b0;
            end
            slot_cnt    <= '0;
            idx         <= '0;
            pend_ovf    <= 1'b0;
            scan_y      <= line_y;
            SPRITE_ADDR <= ATTR_BASE;
            busy        <= 1'b1;
            state       <= ATTR_ADDR;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ATTR_ADDR: begin
                    state <= ATTR_CHK;
                end
                ATTR_CHK: begin
                    cur_x   <= SPRITE_DATA[9:0];
                    cur_col <= SPRITE_DATA[15:10];
                    cur_odd <= attr_dy[0];
                    if (attr_vis && slots_full) begin
                        pend_ovf <= 1'b1;
                    end
                    if (attr_vis && !slots_full) begin
                        SPRITE_ADDR <= row_addr;
                        state       <= ROW_ADDR;
                    end else if (idx == LAST_IDX) begin
                        // Not taking the first branch with attr_vis set means the slots were full.
                        overflow <= pend_ovf | attr_vis;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx         <= idx + 1'b1;
                        SPRITE_ADDR <= attr_addr_next;
                        state       <= ATTR_ADDR;
                    end
                end
                ROW_ADDR: begin
                    state <= ROW_CAP;
                end
                ROW_CAP: begin
                    slots[~bank_sel][slot_cnt[SW-1:0]] <= '{
                        vld:  1'b1,
                        x:    cur_x,
                        col:  cur_col,
                        bits: cur_odd ? SPRITE_DATA[31:16] : SPRITE_DATA[15:0]
                    };
                    slot_cnt <= slot_cnt + 1'b1;
                    if (idx == LAST_IDX) begin
                        overflow <= pend_ovf;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx         <= idx + 1'b1;
                        SPRITE_ADDR <= attr_addr_next;
                        state       <= ATTR_ADDR;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pixel query on the front bank. The loop walks from the highest slot down so
    // that the lowest hitting slot (lowest sprite index) is assigned last and wins.
    logic       hit;
    logic [5:0] hit_col;
    logic [9:0] dx;

    always_comb begin
        hit     = 1'b0;
        hit_col = '0;
        dx      = '0;
        for (int s = MAX_SLOTS - 1; s >= 0; s--) begin
            dx = pix_x - slots[bank_sel][s].x;
            if (slots[bank_sel][s].vld && (dx < 10'd16) &&
                slots[bank_sel][s].bits[4'd15 - dx[3:0]]) begin
                hit     = 1'b1;
                hit_col = slots[bank_sel][s].col;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            pixel_on    <= 1'b0;
            pixel_color <= '0;
        end else begin
            pixel_on    <= hit;
            pixel_color <= hit_col;
        end
    end

endmodule
